// File: rtl/freqin_hz_if.sv
// freqin_hz_if -- bundle between a period measurement source and the
// period-to-frequency converter.
//   period        measured input period in clk cycles
//   period_valid  level, period is meaningful while high
//   freq_hz       last computed frequency in Hz
//   freq_valid    level, freq_hz holds a valid result
//   busy          division in progress
//   done          one-cycle pulse when freq_hz/freq_valid take a new result
interface freqin_hz_if;
    logic [31:0] period;
    logic        period_valid;
    logic [31:0] freq_hz;
    logic        freq_valid;
    logic        busy;
    logic        done;

    modport master (
        output period, period_valid,
        input  freq_hz, freq_valid, busy, done
    );

    modport slave (
        input  period, period_valid,
        output freq_hz, freq_valid, busy, done
    );
endinterface

// File: rtl/freqin_hz.sv
// freqin_hz -- converts a measured period (clk cycles) into a frequency in Hz
// with a sequential radix-2 restoring divider: CLK_FREQ / period, optionally
// rounded to nearest. A division starts only when a new nonzero period shows
// up; the result is held until the next update or invalidation.
//
//   clk   system clock, all logic on posedge
//   rst   synchronous active-high reset
//   bus   freqin_hz_if.slave: period/period_valid in,
//         freq_hz/freq_valid/busy/done out
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a new valid period; invalid input clears result
// DIV    | one quotient bit per cycle, 33 iterations, MSB first
// FINISH | publish the quotient (saturated), pulse done
module freqin_hz #(
    parameter logic [31:0] CLK_FREQ = 32'd50000000,
    parameter bit          ROUND    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    freqin_hz_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [32:0] CLK_FREQ_33 = {1'b0, CLK_FREQ};
    localparam logic [5:0]  LAST_ITER   = 6'd32;

    state_t      state_q, state_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] last_period_q, last_period_d;
    logic        have_last_q, have_last_d;
    logic [32:0] rem_q, rem_d;
    logic [32:0] dq_q, dq_d;          // dividend shifts out the top, quotient shifts in the bottom
    logic [5:0]  iter_q, iter_d;
    logic [31:0] freq_hz_q, freq_hz_d;
    logic        freq_valid_q, freq_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [32:0] dividend;
    logic [32:0] rem_shift;
    logic [33:0] diff;
    logic        ge;
    logic        unused_rem_msb;

    // Rounding adds floor(period/2) so the quotient rounds to nearest.
    assign dividend = CLK_FREQ_33 + (ROUND ? {2'b00, bus.period[31:1]} : 33'd0);

    // The remainder stays below the divisor (< 2^32), so its top bit never
    // carries into the shift.
    assign rem_shift      = {rem_q[31:0], dq_q[32]};
    assign diff           = {1'b0, rem_shift} - {2'b00, divisor_q};
    assign ge             = ~diff[33];
    assign unused_rem_msb = rem_q[32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            divisor_q     <= '0;
            last_period_q <= '0;
            have_last_q   <= 1'b0;
            rem_q         <= '0;
            dq_q          <= '0;
            iter_q        <= '0;
            freq_hz_q     <= '0;
            freq_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            divisor_q     <= divisor_d;
            last_period_q <= last_period_d;
            have_last_q   <= have_last_d;
            rem_q         <= rem_d;
            dq_q          <= dq_d;
            iter_q        <= iter_d;
            freq_hz_q     <= freq_hz_d;
            freq_valid_q  <= freq_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        divisor_d     = divisor_q;
        last_period_d = last_period_q;
        have_last_d   = have_last_q;
        rem_d         = rem_q;
        dq_d          = dq_q;
        iter_d        = iter_q;
        freq_hz_d     = freq_hz_q;
        freq_valid_d  = freq_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.period_valid || (bus.period == 32'd0)) begin
                    freq_hz_d    = '0;
                    freq_valid_d = 1'b0;
                    have_last_d  = 1'b0;
                end else if (!have_last_q || (bus.period != last_period_q)) begin
                    divisor_d     = bus.period;
                    last_period_d = bus.period;
                    have_last_d   = 1'b1;
                    dq_d          = dividend;
                    rem_d         = '0;
                    iter_d        = '0;
                    busy_d        = 1'b1;
                    state_d       = DIV;
                end
            end

            DIV: begin
                if (!bus.period_valid) begin
                    freq_hz_d    = '0;
                    freq_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    have_last_d  = 1'b0;
                    state_d      = IDLE;
                end else begin
                    rem_d  = ge ? diff[32:0] : rem_shift;
                    dq_d   = {dq_q[31:0], ge};
                    iter_d = iter_q + 6'd1;
                    if (iter_q == LAST_ITER) begin
                        state_d = FINISH;
                    end
                end
            end

            FINISH: begin
                freq_hz_d    = dq_q[32] ? 32'hFFFF_FFFF : dq_q[31:0];
                freq_valid_d = 1'b1;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.freq_hz    = freq_hz_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_freqin_hz.sv
module tb_freqin_hz;

    localparam logic [31:0] CLK_HZ = 32'd50000000;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    freqin_hz_if bus1 ();
    freqin_hz_if bus0 ();

    freqin_hz #(.CLK_FREQ(CLK_HZ), .ROUND(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    freqin_hz #(.CLK_FREQ(CLK_HZ), .ROUND(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // Reference: plain integer arithmetic on the frequency formula.
    function automatic logic [31:0] model(input logic [31:0] p, input bit rnd);
        longint unsigned d, q;
        d = longint'(CLK_HZ) + (rnd ? longint'(p / 2) : 64'd0);
        q = d / longint'(p);
        if (q > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return q[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] p);
        bus1.period_valid = v;
        bus1.period       = p;
        bus0.period_valid = v;
        bus0.period       = p;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for done on the ROUND=1 instance; counts edges and busy samples.
    task automatic wait_done(output int cyc, output int busy_cnt, output bit seen);
        cyc = 0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            cyc = i + 1;
            if (bus1.busy) busy_cnt++;
            if (bus1.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic div_check(input string tag, input logic [31:0] p);
        int cyc, bc;
        bit seen;
        set_in(1'b1, p);
        wait_done(cyc, bc, seen);
        chk({tag, "_hz_r1"}, bus1.freq_hz, model(p, 1'b1));
        chk({tag, "_hz_r0"}, bus0.freq_hz, model(p, 1'b0));
        chk({tag, "_fv"}, {31'd0, bus1.freq_valid}, 32'd1);
    endtask

    initial begin
        int cyc, bc, dcnt, bcnt;
        bit seen;
        logic [31:0] p, last;

        rst = 1'b1;
        set_in(1'b0, 32'd0);
        step(2);
        chk("rst_hz", bus1.freq_hz, 32'd0);
        chk("rst_fv", {31'd0, bus1.freq_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus1.busy}, 32'd0);
        chk("rst_done", {31'd0, bus1.done}, 32'd0);

        // First division: latency and busy length.
        rst = 1'b0;
        set_in(1'b1, 32'd50000);
        wait_done(cyc, bc, seen);
        chk("lat_cycles", cyc, 32'd35);
        chk("lat_busy", bc, 32'd34);
        chk("p50000_hz", bus1.freq_hz, 32'd1000);
        chk("p50000_fv", {31'd0, bus1.freq_valid}, 32'd1);
        chk("p50000_busy_end", {31'd0, bus1.busy}, 32'd0);
        step(1);
        chk("done_pulse_1cyc", {31'd0, bus1.done}, 32'd0);

        // Holding the same period must not retrigger.
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 500; i++) begin
            step(1);
            if (bus1.done) dcnt++;
            if (bus1.busy) bcnt++;
        end
        chk("hold_done", dcnt, 32'd0);
        chk("hold_busy", bcnt, 32'd0);
        chk("hold_hz", bus1.freq_hz, 32'd1000);

        div_check("p3", 32'd3);
        chk("p3_r1_exact", bus1.freq_hz, 32'd16666667);
        chk("p3_r0_exact", bus0.freq_hz, 32'd16666666);
        div_check("p1", 32'd1);
        chk("p1_exact", bus1.freq_hz, 32'd50000000);

        // Abort mid-division by dropping valid.
        set_in(1'b1, 32'd1000);
        step(10);
        chk("abort_busy_before", {31'd0, bus1.busy}, 32'd1);
        set_in(1'b0, 32'd1000);
        step(1);
        chk("abort_hz", bus1.freq_hz, 32'd0);
        chk("abort_fv", {31'd0, bus1.freq_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus1.busy}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus1.done) dcnt++;
            step(1);
        end
        chk("abort_no_done", dcnt, 32'd0);
        div_check("p1000_again", 32'd1000);
        chk("p1000_exact", bus1.freq_hz, 32'd50000);

        // Period change during a division is picked up afterwards.
        div_check("p3_b", 32'd3);
        set_in(1'b1, 32'd1000);
        step(5);
        set_in(1'b1, 32'd2000);
        wait_done(cyc, bc, seen);
        chk("chg_first_hz", bus1.freq_hz, 32'd50000);
        wait_done(cyc, bc, seen);
        chk("chg_second_cyc", cyc, 32'd35);
        chk("chg_second_hz", bus1.freq_hz, 32'd25000);

        // Reset mid-division, then a zero period.
        set_in(1'b1, 32'd777);
        step(5);
        rst = 1'b1;
        step(1);
        chk("midrst_hz", bus1.freq_hz, 32'd0);
        chk("midrst_fv", {31'd0, bus1.freq_valid}, 32'd0);
        chk("midrst_busy", {31'd0, bus1.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus1.done}, 32'd0);
        set_in(1'b1, 32'd0);
        rst = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (bus1.busy) bcnt++;
        end
        chk("zero_busy", bcnt, 32'd0);
        chk("zero_fv", {31'd0, bus1.freq_valid}, 32'd0);
        chk("zero_hz", bus1.freq_hz, 32'd0);

        // Randomized periods against the reference model.
        last = 32'd0;
        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0:       p = $urandom_range(100, 1);
                1:       p = $urandom_range(200000, 101);
                default: p = $urandom;
            endcase
            if (p == 32'd0) p = 32'd7;
            if (p == last) p = (last == 32'd5) ? 32'd6 : 32'd5;
            last = p;
            div_check("rand", p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freqin_hz.md
Name: freqin_hz

Overview:
- Downstream consumer of the frequency-input period counter.
- Input is a measured period in clk cycles (one full input-signal period) plus its valid flag. Output is the input frequency in Hz, as a 32-bit integer for the host register map.
- A sequential radix-2 restoring divider computes CLK_FREQ / period. A new division starts only when a new period value appears. The result is held stable between updates.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; legal range 1..2^32-1.
- ROUND, 1, 1 = round to nearest (dividend = CLK_FREQ + floor(period/2)); 0 = truncate (dividend = CLK_FREQ).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- period  in  32  measured period in clk cycles; meaningful only while period_valid=1.
- period_valid  in  1  level; high while the upstream measurement is valid.
- freq_hz  out  32  last computed frequency in Hz.
- freq_valid  out  1  level; freq_hz is a valid result.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse in the cycle freq_hz/freq_valid update with a new result.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; freq_hz=0, freq_valid=0, busy=0, done=0; last_period=0; have_last=0. Reset in any state, including mid-division, aborts immediately with these values.
- States: IDLE, DIV, FINISH.
- IDLE, period_valid=0: freq_hz<=0, freq_valid<=0, have_last<=0.
- IDLE, period_valid=1 and period=0: treated as invalid; same action as period_valid=0.
- IDLE, period_valid=1, period!=0 and (have_last=0 or period!=last_period): start a division.
  - Latch divisor<=period and last_period<=period; set have_last<=1.
  - Load dividend (33 bits); clear remainder (33 bits) and iteration counter; busy<=1; go to DIV.
- IDLE, period_valid=1 and period==last_period with have_last=1: no action; outputs hold.
- DIV: one quotient bit per cycle, MSB first, 33 iterations.
  - rem' = {rem[31:0], dividend MSB}.
  - If rem' >= divisor: subtract divisor and shift in 1; else shift in 0.
  - After the 33rd iteration go to FINISH.
- DIV, period_valid=0 in any cycle: abort to IDLE; freq_hz<=0, freq_valid<=0, busy<=0, have_last<=0, no done pulse.
- DIV, period changes while period_valid=1: ignored; the new value is picked up by the IDLE compare after completion.
- FINISH:
  - freq_hz<=quotient[31:0], or 32'hFFFFFFFF if quotient[32]=1 (saturate; unreachable for legal parameters but required).
  - freq_valid<=1, done<=1 for exactly this one cycle, busy<=0; go to IDLE.
- Latency: start detected at edge N (busy high after N); result and done visible after edge N+34. Back-to-back changing periods therefore yield an update every 35 cycles at most.
- freq_hz and freq_valid change only in FINISH, on an invalidation in IDLE, on an abort in DIV, or on reset. They are glitch-free registers.
- Arithmetic: the dividend fits 33 bits (max CLK_FREQ + 2^31). The divisor is zero-extended to 33 bits. There is no combinational divider; one 33-bit subtractor is shared across iterations.

Test Plan:
- CLK_FREQ=50000000, ROUND=1; period=50000, valid=1 → busy for 34 cycles, then done pulse, freq_hz=1000, freq_valid=1.
- period=3 → freq_hz=16666667 (ROUND=1); same bench with ROUND=0 → 16666666. Then period=1 → 50000000.
- Hold period=50000 valid for 500 cycles after the first result → exactly one done pulse; freq_hz stays 1000; busy stays 0.
- Start a division on period=1000; drop period_valid 10 cycles in → freq_hz=0, freq_valid=0, busy=0, no done. Reassert valid with period=1000 → new division yields 50000.
- Change period from 1000 to 2000 mid-division → first result 50000 (done), then a second division → 25000 (second done) about 35 cycles later.
- Assert rst for one cycle mid-DIV → all outputs 0 the next cycle. period_valid=1 with period=0 → freq_valid=0, freq_hz=0, no busy.
